// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and the memory responder (slave).
// Word-aligned address, per-byte enables, single-cycle ready handshake.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: validates width/alignment, issues one byte-enabled
// word access with a ready timeout, and returns lane-extracted, extended load data.
module load_store_unit #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  output logic                stall,
  output logic                done,
  output logic [31:0]         load_data,
  output logic                err,
  output logic [1:0]          err_code,
  load_store_unit_if.master   mem
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_MISALIGN = 2'b01;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CODE_ILLEGAL  = 2'b11;

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic              store_q;
  logic [31:0]       wdata_q;
  logic [1:0]        code_q;

  logic              illegal;
  logic              misalign;
  logic [1:0]        fault_code;

  logic [1:0]        off;
  logic [3:0]        be;
  logic [31:0]       wdata_lane;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [31:0]       ext;

  // Request validation; an illegal width outranks a misaligned address.
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_store && req_funct3[2]);
    misalign   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    fault_code = CODE_NONE;
    if (illegal)       fault_code = CODE_ILLEGAL;
    else if (misalign) fault_code = CODE_MISALIGN;
  end

  always_comb begin
    off        = addr_q[1:0];
    be         = 4'b1111;
    wdata_lane = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata_q[15:0]}};
      end
      default: begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
      end
    endcase
  end

  always_comb begin
    byte_v = mem.mem_rdata[{off, 3'b000} +: 8];
    half_v = off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    case (f3_q)
      3'b000:  ext = {{24{byte_v[7]}}, byte_v};
      3'b001:  ext = {{16{half_v[15]}}, half_v};
      3'b100:  ext = {24'h0, byte_v};
      3'b101:  ext = {16'h0, half_v};
      default: ext = mem.mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      store_q   <= 1'b0;
      wdata_q   <= '0;
      code_q    <= CODE_NONE;
      load_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            code_q <= fault_code;
            if (fault_code != CODE_NONE) begin
              load_data <= '0;
              state     <= DONE;
            end else begin
              addr_q  <= req_addr;
              f3_q    <= req_funct3;
              store_q <= req_store;
              wdata_q <= req_wdata;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // A ready on the final allowed cycle still completes normally.
          if (mem.mem_ready) begin
            load_data <= store_q ? '0 : ext;
            cnt       <= '0;
            state     <= DONE;
          end else if (cnt == CNT_LAST) begin
            code_q    <= CODE_TIMEOUT;
            load_data <= '0;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          code_q <= CODE_NONE;
          state  <= IDLE;
        end
        default: begin
          code_q <= CODE_NONE;
          cnt    <= '0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Stall is qualified by reset so it drops asynchronously with the FSM.
  assign stall    = reset && (((state == IDLE) && req_valid) || (state == BUSY));
  assign done     = (state == DONE);
  assign err      = (state == DONE) && (code_q != CODE_NONE);
  assign err_code = (state == DONE) ? code_q : CODE_NONE;

  assign mem.mem_req   = (state == BUSY);
  assign mem.mem_we    = (state == BUSY) && store_q;
  assign mem.mem_addr  = (state == BUSY) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem.mem_be    = (state == BUSY) ? be : 4'b0000;
  assign mem.mem_wdata = (state == BUSY) ? wdata_lane : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small word memory answers requests after a
// programmable delay; every result is compared against hand-computed constants.
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] load_data;
  logic        err;
  logic [1:0]  err_code;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.TIMEOUT(16), .ADDR_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .err        (err),
    .err_code   (err_code),
    .mem        (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] mem [0:31];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int          r_done_cyc;
  int          r_req_cyc;
  bit          r_stable;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [31:0] r_ld;
  logic [1:0]  r_ec;
  logic        r_err;
  logic        r_stall1;
  logic        r_stall_done;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // ready_delay < 0 means the responder never answers.
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int ready_delay);
    int busy_n;
    busy_n       = 0;
    r_done_cyc   = 0;
    r_req_cyc    = 0;
    r_stable     = 1'b1;
    r_addr       = '0;
    r_be         = '0;
    r_wdata      = '0;
    r_we         = 1'b0;
    r_ld         = '0;
    r_ec         = '0;
    r_err        = 1'b0;
    r_stall1     = 1'b0;
    r_stall_done = 1'b0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      #1;
      if (cyc == 1) r_stall1 = stall;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      if (bus.mem_req) begin
        if (r_req_cyc == 0) begin
          r_addr  = bus.mem_addr;
          r_be    = bus.mem_be;
          r_wdata = bus.mem_wdata;
          r_we    = bus.mem_we;
        end else if (bus.mem_addr !== r_addr || bus.mem_be !== r_be ||
                     bus.mem_wdata !== r_wdata || bus.mem_we !== r_we) begin
          r_stable = 1'b0;
        end
        r_req_cyc++;
        if (busy_n == ready_delay) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = mem[bus.mem_addr[6:2]];
          if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
              if (bus.mem_be[b]) mem[bus.mem_addr[6:2]][b*8 +: 8] = bus.mem_wdata[b*8 +: 8];
          end
        end
        busy_n++;
      end
      if (done) begin
        r_done_cyc   = cyc;
        r_ld         = load_data;
        r_ec         = err_code;
        r_err        = err;
        r_stall_done = stall;
        break;
      end
      @(negedge clk);
    end
    req_valid     = 1'b0;
    bus.mem_ready = 1'b0;
    if (r_done_cyc == 0) check_eq("txn_done_seen", 32'd0, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    mem[16] = 32'h8C7F_12A4;
    mem[17] = 32'h1122_3344;
    reset         = 1'b0;
    req_valid     = 1'b0;
    req_store     = 1'b0;
    req_funct3    = 3'b000;
    req_addr      = '0;
    req_wdata     = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;

    repeat (3) @(negedge clk);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_err", {err, err_code}, 0);
    check_eq("rst_load_data", load_data, 0);
    check_eq("rst_mem_req", {bus.mem_req, bus.mem_we, bus.mem_be}, 0);
    check_eq("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b1;

    // LB 0x43, ready on first BUSY cycle
    run_txn(1'b0, 3'b000, 32'h43, 32'h0, 0);
    check_eq("lb_stall_accept", r_stall1, 1);
    check_eq("lb_done_cycle", r_done_cyc, 3);
    check_eq("lb_addr", r_addr, 32'h40);
    check_eq("lb_be", r_be, 4'b1000);
    check_eq("lb_we", r_we, 0);
    check_eq("lb_data", r_ld, 32'hFFFF_FF8C);
    check_eq("lb_err", {r_err, r_ec}, 0);
    check_eq("lb_stall_done", r_stall_done, 0);

    run_txn(1'b0, 3'b101, 32'h42, 32'h0, 0);
    check_eq("lhu_be", r_be, 4'b1100);
    check_eq("lhu_data", r_ld, 32'h0000_8C7F);

    run_txn(1'b0, 3'b001, 32'h40, 32'h0, 0);
    check_eq("lh0_be", r_be, 4'b0011);
    check_eq("lh0_data", r_ld, 32'h0000_12A4);

    run_txn(1'b0, 3'b001, 32'h42, 32'h0, 0);
    check_eq("lh2_data", r_ld, 32'hFFFF_8C7F);

    run_txn(1'b0, 3'b100, 32'h43, 32'h0, 0);
    check_eq("lbu_data", r_ld, 32'h0000_008C);

    // SB 0xEE at 0x45, then read the word back
    run_txn(1'b1, 3'b000, 32'h45, 32'h0000_00EE, 0);
    check_eq("sb_we", r_we, 1);
    check_eq("sb_addr", r_addr, 32'h44);
    check_eq("sb_be", r_be, 4'b0010);
    check_eq("sb_wdata", r_wdata, 32'hEEEE_EEEE);
    check_eq("sb_load_data", r_ld, 0);
    check_eq("sb_done_cycle", r_done_cyc, 3);

    run_txn(1'b0, 3'b010, 32'h44, 32'h0, 0);
    check_eq("lw_be", r_be, 4'b1111);
    check_eq("lw_readback", r_ld, 32'h1122_EE44);

    run_txn(1'b1, 3'b001, 32'h46, 32'h0000_ABCD, 0);
    check_eq("sh_be", r_be, 4'b1100);
    check_eq("sh_wdata", r_wdata, 32'hABCD_ABCD);
    run_txn(1'b0, 3'b010, 32'h44, 32'h0, 0);
    check_eq("sh_readback", r_ld, 32'hABCD_EE44);

    // Faults: no memory request, done on the second cycle
    run_txn(1'b1, 3'b010, 32'h42, 32'h1234_5678, 0);
    check_eq("sw_mis_req", r_req_cyc, 0);
    check_eq("sw_mis_done_cycle", r_done_cyc, 2);
    check_eq("sw_mis_err", {r_err, r_ec}, 3'b101);
    check_eq("sw_mis_stall", r_stall1, 1);
    check_eq("sw_mis_load_data", r_ld, 0);

    run_txn(1'b0, 3'b011, 32'h40, 32'h0, 0);
    check_eq("f3_011_err", {r_err, r_ec}, 3'b111);
    check_eq("f3_011_req", r_req_cyc, 0);

    run_txn(1'b1, 3'b100, 32'h40, 32'h0, 0);
    check_eq("store_bu_err", {r_err, r_ec}, 3'b111);

    run_txn(1'b0, 3'b111, 32'h41, 32'h0, 0);
    check_eq("illegal_prio", {r_err, r_ec}, 3'b111);

    run_txn(1'b0, 3'b101, 32'h41, 32'h0, 0);
    check_eq("lhu_mis_err", {r_err, r_ec}, 3'b101);

    // Never ready: 16 request cycles then a bus timeout
    run_txn(1'b0, 3'b010, 32'h40, 32'h0, -1);
    check_eq("to_req_cycles", r_req_cyc, 16);
    check_eq("to_done_cycle", r_done_cyc, 18);
    check_eq("to_err", {r_err, r_ec}, 3'b110);
    check_eq("to_load_data", r_ld, 0);

    // Ready after 5 wait cycles
    run_txn(1'b0, 3'b000, 32'h41, 32'h0, 5);
    check_eq("dly_req_cycles", r_req_cyc, 6);
    check_eq("dly_stable", r_stable, 1);
    check_eq("dly_done_cycle", r_done_cyc, 8);
    check_eq("dly_data", r_ld, 32'h0000_0012);
    check_eq("dly_err", {r_err, r_ec}, 0);
    @(negedge clk);
    #1;
    check_eq("hold_done", done, 0);
    check_eq("hold_err", {err, err_code}, 0);
    check_eq("hold_load_data", load_data, 32'h0000_0012);

    // Reset in the middle of BUSY
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    repeat (3) @(negedge clk);
    #1;
    check_eq("mid_busy_req", bus.mem_req, 1);
    #1;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_req", bus.mem_req, 0);
    check_eq("mid_rst_stall", stall, 0);
    check_eq("mid_rst_done", done, 0);
    req_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("rst_held_done", done, 0);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_eq("post_rst_done", done, 0);
    check_eq("post_rst_req", bus.mem_req, 0);

    run_txn(1'b0, 3'b010, 32'h40, 32'h0, 0);
    check_eq("post_rst_lw_cycle", r_done_cyc, 3);
    check_eq("post_rst_lw_data", r_ld, 32'h8C7F_12A4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage initiator for the byte-addressable data memory interface.
- Takes a pipeline load/store request and validates its width and alignment.
- Drives a word-aligned, byte-enabled request to the memory responder and waits for the ready handshake with a timeout.
- Returns lane-aligned, sign/zero-extended load data. Stalls the pipeline for the whole transaction.

Parameters:
- TIMEOUT, 16, max cycles in BUSY without mem_ready before a bus error (≥2).
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  MEM stage holds a load/store; held high while stall=1.
- req_store  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, rs2 value.
- stall  out  1  freeze the pipeline.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result; valid while done=1.
- err  out  1  one-cycle error pulse, coincident with done.
- err_code  out  2  01 misaligned, 10 bus timeout, 11 illegal funct3; 00 when no error.
- mem_req  out  1  request valid toward memory.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned address, req_addr with [1:0] forced to 00.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ready  in  1  responder accepts/completes the request this cycle.
- mem_rdata  in  32  read word; sampled when mem_ready=1.

Behaviour:
- **Reset (reset=0, async):**
  - state=IDLE, timeout counter=0.
  - All outputs 0: stall, done, err, err_code, load_data, mem_*.
  - A reset mid-BUSY drops mem_req immediately. No done is produced.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE with req_valid=1, legal and aligned:**
  - Latch address, funct3, store flag and data into internal registers.
  - Next state BUSY. stall=1 combinationally in this cycle.
- **IDLE with req_valid=1 and a fault:**
  - Faults: illegal funct3 (011, 110, 111, or a store with 1xx), or misalignment (H/HU with addr[0]=1, W with addr[1:0]≠00).
  - Next state DONE with err latched. No memory request is issued. stall=1 this cycle.
  - Illegal funct3 takes priority over misalignment.
- **BUSY:**
  - mem_req=1. All mem_* come from the latched registers and are stable until mem_ready is sampled high.
  - stall=1.
  - The counter increments each BUSY cycle.
- **BUSY, mem_ready=1:**
  - For a load, register the extracted data into load_data. Store data has no response.
  - Next state DONE. mem_req drops the following cycle.
- **BUSY timeout:** the counter reaches TIMEOUT-1 with mem_ready=0. Latch err_code=10, next state DONE. The counter clears on leaving BUSY.
- **DONE:**
  - done=1, stall=0. err and err_code are driven if latched.
  - Next state IDLE.
  - req_valid in this cycle belongs to the retiring instruction and is ignored.
- **Latency:**
  - Min 3 cycles for an access (accept, BUSY with ready, DONE).
  - 2 cycles for a faulted request.
  - Back-to-back requests are accepted from the IDLE cycle after DONE.
- **Lane rules** (off = addr[1:0]):
  - Store byte: be = 0001<<off; wdata = {4{wdata[7:0]}}.
  - Store halfword: be = 0011<<off (off ∈ {0,2}); wdata = {2{wdata[15:0]}}.
  - Store word: be = 1111; wdata unchanged.
  - Loads: mem_we=0, be per width.
  - Extract the byte at rdata[8*off+:8] or the half at rdata[16*off[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- **load_data** holds its value until the next completed load. It is 0 after a store or fault completion.

Test Plan:
- Memory word 0x8C7F_12A4 at 0x40. LB at 0x43, ready on first BUSY cycle → mem_addr=0x40, be=1000, done at cycle 3, load_data=0xFFFF_FF8C.
- LHU at 0x42 on the same word → be=1100, load_data=0x0000_8C7F. LH at 0x40 → load_data=0x0000_12A4.
- SB wdata=0x0000_00EE at 0x45 → mem_we=1, mem_addr=0x44, be=0010, mem_wdata=0xEEEE_EEEE. Read-back LW 0x44 shows only byte 1 changed.
- SW at 0x42 → no mem_req ever asserted, err=1, err_code=01, done on the 2nd cycle. funct3=011 → err_code=11.
- mem_ready held 0, TIMEOUT=16 → mem_req high exactly 16 cycles, then done with err_code=10. mem_ready delayed 5 cycles → mem_* stable all 5 cycles, normal completion.
- Assert reset=0 during BUSY → mem_req and stall drop asynchronously, no done. After release, a new LW completes normally.
